// File: rtl/cordic_dir_seq.sv
// -----------------------------------------------------------------------------
// cordic_dir_seq
//
// Control sequencer for an iterative CORDIC datapath. After START it walks the
// iteration index k over the configured range, one index per enabled cycle.
// For each step it emits the shift amount / angle-ROM address (SHIFT), the
// rotation direction (SIGMA) and the datapath register enable (STEP). In
// hyperbolic mode the indices 4, 13 and 40 are executed twice, which keeps
// the hyperbolic iteration convergent. The second pass is flagged on REPEAT.
//
// Parameters
//   W     width of the signed Z / Y residuals
//   ITER  logical iteration count, not counting repeats (1..48)
//   HYP   1 = hyperbolic (k = 1..ITER, with repeats), 0 = circular (k = 0..ITER-1)
//
// Ports
//   CLK     clock, rising edge
//   RST     synchronous active-high reset
//   START   begin a sequence (only looked at while idle)
//   MODE    0 = rotation (direction from Z sign), 1 = vectoring (from Y sign)
//   HOLD    datapath stall; freezes the sequence while high
//   Z_IN    current Z residual
//   Y_IN    current Y residual
//   SHIFT   current iteration index k (0 outside RUN)
//   SIGMA   direction, 1 = +1, 0 = -1 (0 whenever STEP is low)
//   STEP    datapath register enable for the current iteration
//   REPEAT  high on the second pass of a repeated hyperbolic index
//   BUSY    high while the sequence is running
//   DONE    one-cycle completion pulse
// -----------------------------------------------------------------------------
module cordic_dir_seq #(
  parameter int W    = 32,
  parameter int ITER = 16,
  parameter int HYP  = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         MODE,
  input  logic         HOLD,
  input  logic [W-1:0] Z_IN,
  input  logic [W-1:0] Y_IN,
  output logic [5:0]   SHIFT,
  output logic         SIGMA,
  output logic         STEP,
  output logic         REPEAT,
  output logic         BUSY,
  output logic         DONE
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // First and last index of the walk. Hyperbolic CORDIC has no k=0 term.
  localparam logic [5:0] K_FIRST = (HYP != 0) ? 6'd1 : 6'd0;
  localparam logic [5:0] K_LAST  = (HYP != 0) ? 6'(ITER) : 6'(ITER - 1);

  // Indices that must be executed twice in hyperbolic mode. k never exceeds
  // K_LAST while running, so membership alone implies "within 1..ITER".
  function automatic logic is_rep_idx(input logic [5:0] k);
    logic hit;
    hit = (k == 6'd4) || (k == 6'd13) || (k == 6'd40);
    return (HYP != 0) && hit;
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] k_r;
  logic [5:0] k_nxt_s;
  logic       rep_r;
  logic       rep_nxt_s;
  logic       mode_r;
  logic       mode_nxt_s;

  logic       run_s;
  logic       step_s;
  logic       rep_pending_s;
  logic       z_neg_s;
  logic       y_neg_s;

  assign run_s  = (state_r == ST_RUN);
  assign step_s = run_s & ~HOLD;

  // A repeat index whose second pass has not been taken yet keeps k in place.
  assign rep_pending_s = is_rep_idx(k_r) & ~rep_r;

  // Sign of each residual, taken as a signed compare of the whole word.
  assign z_neg_s = ($signed(Z_IN) < $signed({W{1'b0}}));
  assign y_neg_s = ($signed(Y_IN) < $signed({W{1'b0}}));

  // State, index, repeat flag and latched mode registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      k_r     <= 6'd0;
      rep_r   <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      rep_r   <= rep_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  // Next-state, next-index and repeat-flag logic.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    rep_nxt_s   = rep_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_nxt_s = ST_RUN;
          mode_nxt_s  = MODE;
          k_nxt_s     = K_FIRST;
          rep_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_s) begin
          if (rep_pending_s) begin
            // First pass of a repeat index: take the second pass next.
            rep_nxt_s   = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            rep_nxt_s = 1'b0;
            k_nxt_s   = k_r + 6'd1;
            if (k_r == K_LAST) begin
              state_nxt_s = ST_FIN;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end
        end else begin
          // Stalled: everything holds.
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIN: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        k_nxt_s     = 6'd0;
        rep_nxt_s   = 1'b0;
      end
    endcase
  end

  // Output decode from the registered state plus the live residual signs.
  always_comb begin
    BUSY   = run_s;
    DONE   = (state_r == ST_FIN);
    STEP   = step_s;
    REPEAT = run_s & rep_r;
    if (run_s) begin
      SHIFT = k_r;
    end else begin
      SHIFT = 6'd0;
    end
    if (step_s) begin
      if (mode_r) begin
        // Vectoring drives Y toward zero: rotate up when Y is negative.
        SIGMA = y_neg_s;
      end else begin
        // Rotation drives Z toward zero: Z = 0 counts as non-negative.
        SIGMA = ~z_neg_s;
      end
    end else begin
      SIGMA = 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_dir_seq.sv
// -----------------------------------------------------------------------------
// tb_cordic_dir_seq
//
// Drives a hyperbolic instance (ITER=16) and a circular instance (ITER=8)
// from the same stimulus. Each instance's expected index walk is built up
// front as a list of (k, repeat) pairs. A per-cycle model then tracks only
// "idle / running at list position n / finishing". A negedge process compares
// every output of both instances against that model. Directed sequences also
// check lengths and DONE timing. A random phase follows them.
// -----------------------------------------------------------------------------
module tb_cordic_dir_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        MODE;
  logic        HOLD;
  logic [31:0] Z_IN;
  logic [31:0] Y_IN;

  logic [5:0]  shift0, shift1;
  logic        sigma0, sigma1, step0, step1, repeat0, repeat1;
  logic        busy0, busy1, done0, done1;

  always #5 CLK = ~CLK;

  cordic_dir_seq #(.W(32), .ITER(16), .HYP(1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .HOLD(HOLD),
    .Z_IN(Z_IN), .Y_IN(Y_IN),
    .SHIFT(shift0), .SIGMA(sigma0), .STEP(step0), .REPEAT(repeat0),
    .BUSY(busy0), .DONE(done0)
  );

  cordic_dir_seq #(.W(32), .ITER(8), .HYP(0)) dut_c (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .HOLD(HOLD),
    .Z_IN(Z_IN), .Y_IN(Y_IN),
    .SHIFT(shift1), .SIGMA(sigma1), .STEP(step1), .REPEAT(repeat1),
    .BUSY(busy1), .DONE(done1)
  );

  logic [5:0] o_shift [2];
  logic       o_sigma [2];
  logic       o_step  [2];
  logic       o_rep   [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  assign o_shift[0] = shift0;  assign o_shift[1] = shift1;
  assign o_sigma[0] = sigma0;  assign o_sigma[1] = sigma1;
  assign o_step[0]  = step0;   assign o_step[1]  = step1;
  assign o_rep[0]   = repeat0; assign o_rep[1]   = repeat1;
  assign o_busy[0]  = busy0;   assign o_busy[1]  = busy1;
  assign o_done[0]  = done0;   assign o_done[1]  = done1;

  // Expected walk per instance: the list of (k, repeat) steps.
  int seq_k [2][64];
  bit seq_r [2][64];
  int seq_n [2];

  // Abstract per-instance model state.
  bit m_run  [2];
  bit m_fin  [2];
  bit m_mode [2];
  int m_idx  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_seq(input int d, input bit hyp, input int iter);
    int first, last, n;
    first = hyp ? 1 : 0;
    last  = hyp ? iter : iter - 1;
    n = 0;
    for (int k = first; k <= last; k++) begin
      seq_k[d][n] = k; seq_r[d][n] = 1'b0; n++;
      if (hyp && (k == 4 || k == 13 || k == 40)) begin
        seq_k[d][n] = k; seq_r[d][n] = 1'b1; n++;
      end
    end
    seq_n[d] = n;
  endtask

  // Model update at each rising edge from the inputs stable at that edge.
  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (RST) begin
        m_run[d] <= 1'b0; m_fin[d] <= 1'b0; m_idx[d] <= 0;
      end else if (m_fin[d]) begin
        m_fin[d] <= 1'b0;
      end else if (m_run[d]) begin
        if (!HOLD) begin
          m_idx[d] <= m_idx[d] + 1;
          if (m_idx[d] + 1 == seq_n[d]) begin
            m_run[d] <= 1'b0; m_fin[d] <= 1'b1;
          end
        end
      end else if (START) begin
        m_run[d] <= 1'b1; m_idx[d] <= 0; m_mode[d] <= MODE;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic       e_step, e_sig;
        logic [5:0] e_shift;
        logic       e_rep;
        e_step  = m_run[d] && !HOLD;
        e_shift = m_run[d] ? 6'(seq_k[d][m_idx[d]]) : 6'd0;
        e_rep   = m_run[d] ? seq_r[d][m_idx[d]] : 1'b0;
        e_sig   = e_step ? (m_mode[d] ? Y_IN[31] : !Z_IN[31]) : 1'b0;
        chk($sformatf("d%0d BUSY", d),   32'(o_busy[d]),  32'(m_run[d]));
        chk($sformatf("d%0d DONE", d),   32'(o_done[d]),  32'(m_fin[d]));
        chk($sformatf("d%0d STEP", d),   32'(o_step[d]),  32'(e_step));
        chk($sformatf("d%0d SHIFT", d),  32'(o_shift[d]), 32'(e_shift));
        chk($sformatf("d%0d REPEAT", d), 32'(o_rep[d]),   32'(e_rep));
        chk($sformatf("d%0d SIGMA", d),  32'(o_sigma[d]), 32'(e_sig));
      end
    end
  end

  // One directed sequence: START, then optional HOLD window, RST, START spam.
  task automatic run_seq(input string name, input bit mode, input int hold_at,
                         input int hold_len, input int rst_at, input bit spam,
                         input int exp_busy, input bit exp_done, input int exp_busy_c);
    int busy_cnt, busy_c, steps, last_step_cyc, done_cyc;
    bit done_seen;
    busy_cnt = 0; busy_c = 0; steps = 0; last_step_cyc = 0; done_cyc = 0;
    done_seen = 1'b0;
    START = 1'b1; MODE = mode; HOLD = 1'b0; RST = 1'b0;
    Z_IN = 32'h0; Y_IN = 32'h0;
    @(posedge CLK); #1;
    for (int cyc = 1; cyc <= 40 && !done_seen; cyc++) begin
      START = spam;
      HOLD  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      RST   = (cyc == rst_at);
      Z_IN  = 32'h0;
      Y_IN  = cyc[0] ? 32'h8000_0000 : 32'h0000_0001;
      @(negedge CLK);
      if (busy0) busy_cnt++;
      if (busy1) busy_c++;
      if (step0) begin steps++; last_step_cyc = cyc; end
      if (done0) begin done_seen = 1'b1; done_cyc = cyc; end
      @(posedge CLK); #1;
    end
    START = 1'b0; RST = 1'b0; HOLD = 1'b0;
    chk({name, " run cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({name, " step count"}, 32'(steps), 32'(exp_busy - hold_len));
    chk({name, " done seen"}, 32'(done_seen), 32'(exp_done));
    if (exp_done) chk({name, " done delay"}, 32'(done_cyc - last_step_cyc), 32'd1);
    if (exp_busy_c >= 0) chk({name, " circ run cycles"}, 32'(busy_c), 32'(exp_busy_c));
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; MODE = 1'b0; HOLD = 1'b0;
    Z_IN = 32'h0; Y_IN = 32'h0;
    build_seq(0, 1'b1, 16);
    build_seq(1, 1'b0, 8);

    // Hand-computed pins on the expected walks.
    chk("walk hyp length", 32'(seq_n[0]), 32'd18);
    chk("walk hyp first k", 32'(seq_k[0][0]), 32'd1);
    chk("walk hyp 5th k", 32'(seq_k[0][4]), 32'd4);
    chk("walk hyp 5th repeat", 32'(seq_r[0][4]), 32'd1);
    chk("walk hyp 15th k", 32'(seq_k[0][14]), 32'd13);
    chk("walk hyp 15th repeat", 32'(seq_r[0][14]), 32'd1);
    chk("walk hyp last k", 32'(seq_k[0][17]), 32'd16);
    chk("walk circ length", 32'(seq_n[1]), 32'd8);
    chk("walk circ first k", 32'(seq_k[1][0]), 32'd0);
    chk("walk circ last k", 32'(seq_k[1][7]), 32'd7);

    @(posedge CLK); #1;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    run_seq("hyp_rot",    1'b0, 0, 0, 0, 1'b0, 18, 1'b1, 8);
    run_seq("vec_alt",    1'b1, 0, 0, 0, 1'b0, 18, 1'b1, -1);
    run_seq("hold_k4",    1'b0, 4, 3, 0, 1'b0, 21, 1'b1, -1);
    run_seq("rst_k7",     1'b0, 0, 0, 7, 1'b0, 7,  1'b0, -1);
    run_seq("restart",    1'b0, 0, 0, 0, 1'b0, 18, 1'b1, 8);
    run_seq("start_spam", 1'b0, 0, 0, 0, 1'b1, 18, 1'b1, -1);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      RST   = ($urandom_range(0, 63) == 0);
      START = ($urandom_range(0, 3) == 0);
      MODE  = $urandom_range(0, 1);
      HOLD  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: Z_IN = 32'h0;
        1: Z_IN = 32'h8000_0000;
        default: Z_IN = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: Y_IN = 32'h0;
        1: Y_IN = 32'h8000_0000;
        default: Y_IN = $urandom;
      endcase
      @(posedge CLK); #1;
    end
    RST = 1'b0; START = 1'b0; HOLD = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_dir_seq.md
CORDIC_DIR_SEQ -- requirements
Module: cordic_dir_seq

Interface
REQ-001 SHALL have parameter W, default 32: width of the signed two's-complement Z and Y residuals.
REQ-002 SHALL have parameter ITER, default 16, legal range 1..48: logical iteration count, excluding repeats.
REQ-003 SHALL have parameter HYP, default 1: 1 selects hyperbolic sequencing, 0 selects circular sequencing.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, all state updates on the rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1 bit: begin a sequence; sampled only in IDLE.
REQ-007 SHALL have port MODE, input, 1 bit: 0 selects rotation, 1 selects vectoring; latched on an accepted START.
REQ-008 SHALL have port HOLD, input, 1 bit: stall request from the datapath.
REQ-009 SHALL have port Z_IN, input, W bits: current Z residual.
REQ-010 SHALL have port Y_IN, input, W bits: current Y residual.
REQ-011 SHALL have port SHIFT, output, 6 bits: current iteration index k, used as the shift amount and the angle-ROM address.
REQ-012 SHALL have port SIGMA, output, 1 bit: direction, 1 = +1 and 0 = -1.
REQ-013 SHALL have port STEP, output, 1 bit: datapath register enable for the current iteration.
REQ-014 SHALL have port REPEAT, output, 1 bit: high while the current step is the second pass of a repeated hyperbolic index.
REQ-015 SHALL have port BUSY, output, 1 bit: high in RUN.
REQ-016 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, RUN and FIN, each held in a registered state variable.
REQ-018 SHALL go IDLE->RUN on START=1; the same edge latches MODE and loads k=1 (HYP=1) or k=0 (HYP=0), and clears the repeat flag.
REQ-019 SHALL ignore START while in RUN or FIN.
REQ-020 SHALL drive STEP = (state==RUN) & ~HOLD.
REQ-021 SHALL, in rotation mode, compute SIGMA = ~Z_IN[W-1], so Z_IN=0 gives SIGMA=1.
REQ-022 SHALL, in vectoring mode, compute SIGMA = Y_IN[W-1].
REQ-023 SHALL make SIGMA combinational from the residual inputs and force it to 0 whenever STEP=0.
REQ-024 SHALL, with HOLD=1 in RUN, freeze k, the repeat flag and the state.
REQ-025 SHALL, with HYP=1, execute each index k in {4,13,40} that lies within 1..ITER twice; the second pass has REPEAT=1 and the same SHIFT.
REQ-026 SHALL advance on each STEP cycle: if k is a repeat index and the repeat flag is clear, set the flag and keep k; otherwise clear the flag and increment k.
REQ-027 SHALL go RUN->FIN on the STEP cycle that completes the last index (k=ITER for HYP=1, k=ITER-1 for HYP=0), including that index's repeat pass.
REQ-028 SHALL spend exactly one cycle in FIN with DONE=1, then go to IDLE.
REQ-029 SHALL have RUN length, with no HOLD, equal to ITER plus the number of repeat indices in range (ITER=16, HYP=1 gives 18 cycles).
REQ-030 SHALL drive SHIFT to the registered k in RUN and to 0 in IDLE and FIN.
REQ-031 SHALL drive REPEAT to the registered flag qualified by RUN.

Reset
REQ-032 SHALL, with RST=1, force state=IDLE, k=0, flag=0, and SHIFT=0, SIGMA=0, STEP=0, REPEAT=0, BUSY=0, DONE=0 on the next edge.
REQ-033 SHALL give RST priority over START and HOLD.
REQ-034 SHALL abort an in-progress sequence on RST mid-RUN with no DONE pulse.
REQ-035 SHALL honour START on the first edge after RST deasserts.

Verification
REQ-036 SHALL cover: HYP=1, ITER=16, rotation, Z_IN held at 0 -> 18 STEP cycles, SHIFT=1,2,3,4,4,5..13,13,14,15,16, REPEAT high on the 5th and 15th steps, SIGMA=1 throughout, DONE one cycle after the last step.
REQ-037 SHALL cover: HYP=0, ITER=8 -> SHIFT=0..7, REPEAT never high, DONE after 8 steps.
REQ-038 SHALL cover: vectoring, Y_IN alternating 0x80000000 / 0x00000001 -> SIGMA alternating 1/0.
REQ-039 SHALL cover: HOLD=1 for 3 cycles at k=4 (first pass) -> STEP=0, SIGMA=0, SHIFT stays 4, the repeat pass still occurs, total cycles = 18+3.
REQ-040 SHALL cover: RST at k=7 -> all outputs 0 next cycle, no DONE, and a new START then gives a full sequence.
REQ-041 SHALL cover: START pulsed during RUN and FIN -> ignored, sequence length unchanged.
